// File: rtl/mips_fetch.sv
// -----------------------------------------------------------------------------
// mips_fetch
//
// Instruction-fetch stage feeding mips_decode. Holds the PC, issues word
// requests to instruction memory over a valid/ready handshake, buffers the
// in-order responses in a DEPTH-entry FIFO and presents {inst, inst_pc} to
// the decode stage over a second valid/ready handshake. Redirect targets are
// computed from the decoder's control_type encoding.
//
// Parameters
//   DEPTH     FIFO entries; also the cap on outstanding + stale + occupancy
//   RESET_PC  PC value after reset
//
// Ports
//   clock, reset        clock; asynchronous active-high reset
//   imem_req_valid/ready, imem_addr     request channel to instruction memory
//   imem_resp_valid/data                in-order response channel
//   inst_valid/ready, inst, inst_pc     FIFO head towards decode
//   redirect_type/base/imm/jidx/reg     single-cycle redirect from decode
//                                       (00 none, 01 branch, 10 jump, 11 jr)
//   fetch_except                        misaligned redirect target flag
//
// Optional feature
//   FETCH_ALIGN_CHECK_EN  when defined, a misaligned redirect target raises
//                         fetch_except and halts fetching until an aligned
//                         redirect arrives. When undefined the target's low
//                         two bits are forced to zero and fetch_except is 0.
// -----------------------------------------------------------------------------
module mips_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_base,
    input  logic [15:0] redirect_imm,
    input  logic [25:0] redirect_jidx,
    input  logic [31:0] redirect_reg,
    output logic        fetch_except
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW+1:0]  L_DEPTH = (CW + 2)'(DEPTH);
    localparam logic [PW-1:0]  L_LAST  = PW'(DEPTH - 1);

    // Architectural state
    logic [31:0]   r_pc;          // address of the next request
    logic [31:0]   r_resp_pc;     // PC belonging to the next live response
    logic [CW-1:0] r_outstanding; // live requests awaiting a response
    logic [CW-1:0] r_stale;       // requests whose responses must be dropped
    logic [CW-1:0] r_count;       // FIFO occupancy
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;

    // FIFO storage (no reset; outputs are masked while empty)
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic [CW+1:0] w_inflight;
    logic          w_halted;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_redirect;
    logic          w_live_resp;
    logic          w_resp_stale;
    logic          w_push;
    logic          w_pop;
    logic          w_inst_valid;
    logic [31:0]   w_target_raw;
    logic [31:0]   w_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic          r_halted;
    logic          r_except;
    logic          w_misaligned;

    assign w_target     = w_target_raw;
    assign w_misaligned = (w_target_raw[1:0] != 2'b00);
    assign w_halted     = r_halted;
    assign fetch_except = r_except;
`else
    assign w_target     = w_target_raw & 32'hFFFF_FFFC;
    assign w_halted     = 1'b0;
    assign fetch_except = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == L_LAST) ? '0 : p + PW'(1);
    endfunction

    // Redirect target, decoded from the decoder's control_type
    always_comb begin
        w_target_raw = redirect_reg;
        case (redirect_type)
            2'b01:   w_target_raw = redirect_base + {{14{redirect_imm[15]}}, redirect_imm, 2'b00};
            2'b10:   w_target_raw = {redirect_base[31:28], redirect_jidx, 2'b00};
            default: w_target_raw = redirect_reg;
        endcase
    end

    // Credit: every accepted request needs a FIFO slot reserved until its
    // response has been either dropped or popped, so the sum is bounded.
    assign w_inflight   = (CW + 2)'(r_outstanding) + (CW + 2)'(r_stale) + (CW + 2)'(r_count);
    assign w_req_valid  = ~reset & ~w_halted & (w_inflight < L_DEPTH);
    assign w_req_fire   = w_req_valid & imem_req_ready;
    assign w_redirect   = (redirect_type != 2'b00);
    assign w_resp_stale = imem_resp_valid & (r_stale != '0);
    assign w_live_resp  = imem_resp_valid & (r_stale == '0);
    // A live response arriving together with a redirect belongs to the old
    // path and is never written.
    assign w_push       = w_live_resp & ~w_redirect;
    assign w_inst_valid = (r_count != '0);
    assign w_pop        = w_inst_valid & inst_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc & 32'hFFFF_FFFC;
    assign inst_valid     = w_inst_valid;
    assign inst           = w_inst_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign inst_pc        = w_inst_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_halted      <= 1'b0;
            r_except      <= 1'b0;
`endif
        end else if (w_redirect) begin
            r_pc          <= w_target;
            r_resp_pc     <= w_target;
            // Everything still in flight after this cycle belongs to the old
            // path: previous stale + live outstanding + this cycle's request,
            // minus whichever response (stale or live) arrives right now.
            r_stale       <= r_stale + r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
            r_outstanding <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_halted      <= w_misaligned;
            r_except      <= w_misaligned;
`endif
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_live_resp);
            if (w_resp_stale) begin
                r_stale <= r_stale - CW'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wr_ptr  <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_resp_data;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule
